// File: rtl/nand_timing_engine.sv
// nand_timing_engine: NAND-flash pad timing engine for command/address latch,
// single/burst read/write and wait-for-ready, with programmable phase widths.
module nand_timing_engine #(
    parameter int CNT_W    = 12,
    parameter int T_SETUP  = 1,
    parameter int T_PULSE  = 2,
    parameter int T_HOLD   = 1,
    parameter int T_WB     = 4,
    parameter int T_RB_MAX = 1024
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             start,
    input  logic [2:0]       cmd_code,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             RB_n,
    output logic             CE_n,
    output logic             CLE,
    output logic             ALE,
    output logic             WE_n,
    output logic             RE_n,
    output logic             DOS,
    output logic             DIS,
    output logic             cnt_en,
    output logic             ecc_en,
    output logic             busy,
    output logic             Done,
    output logic             err
);
    localparam int T_M1  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_M2  = (T_M1 > T_HOLD) ? T_M1 : T_HOLD;
    localparam int T_MAX = (T_M2 > T_RB_MAX) ? T_M2 : T_RB_MAX;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] L_SETUP = TW'(T_SETUP);
    localparam logic [TW-1:0] L_PULSE = TW'(T_PULSE);
    localparam logic [TW-1:0] L_HOLD  = TW'(T_HOLD);
    localparam logic [TW-1:0] L_WB    = TW'(T_WB);
    localparam logic [TW-1:0] L_RBMAX = TW'(T_RB_MAX);
    localparam logic [TW-1:0] L_ONE   = TW'(1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;
    localparam state_t S_FIRST = (T_SETUP > 0) ? S_SETUP : S_PULSE;

    state_t           r_state, w_state;
    logic [TW-1:0]    r_tmr, w_tmr;
    logic [CNT_W-1:0] r_beats, w_beats;
    logic [2:0]       r_code, w_code;
    logic             r_rb1, r_rb2;
    logic             w_done, w_err, w_act, w_wr, w_last;

    always_comb begin
        w_state = r_state;
        w_tmr   = r_tmr + L_ONE;
        w_beats = r_beats;
        w_code  = r_code;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_code  = cmd_code;
                w_beats = (cmd_code[2] && burst_len != '0) ? burst_len : CNT_W'(1);
                w_state = (cmd_code == 3'b011) ? S_WAIT : S_FIRST;
                w_tmr   = L_ONE;
            end
            S_SETUP: if (r_tmr == L_SETUP) begin
                w_state = S_PULSE;
                w_tmr   = L_ONE;
            end
            S_PULSE: if (r_tmr == L_PULSE) begin
                w_state = S_HOLD;
                w_tmr   = L_ONE;
            end
            S_HOLD: if (r_tmr == L_HOLD) begin
                w_tmr   = L_ONE;
                w_state = (r_beats > CNT_W'(1)) ? S_FIRST : S_IDLE;
                w_beats = (r_beats > CNT_W'(1)) ? r_beats - CNT_W'(1) : r_beats;
                w_done  = (r_beats <= CNT_W'(1));
            end
            S_WAIT: if ((r_tmr >= L_WB && r_rb2) || r_tmr == L_RBMAX) begin
                w_state = S_IDLE;
                w_done  = 1'b1;
                w_err   = !(r_tmr >= L_WB && r_rb2);
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it cycle for cycle.
    assign w_act  = (w_state == S_SETUP) || (w_state == S_PULSE) || (w_state == S_HOLD);
    assign w_wr   = w_code[2] ? w_code[1] : !w_code[1];
    assign w_last = (w_state == S_HOLD) && (w_tmr == L_HOLD);

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_beats <= '0;
            r_code  <= '0;
            r_rb1   <= 1'b1;
            r_rb2   <= 1'b1;
            CE_n    <= 1'b1;
            CLE     <= 1'b0;
            ALE     <= 1'b0;
            WE_n    <= 1'b1;
            RE_n    <= 1'b1;
            DOS     <= 1'b0;
            DIS     <= 1'b0;
            cnt_en  <= 1'b0;
            ecc_en  <= 1'b0;
            busy    <= 1'b0;
            Done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state;
            r_tmr   <= w_tmr;
            r_beats <= w_beats;
            r_code  <= w_code;
            r_rb1   <= RB_n;
            r_rb2   <= r_rb1;
            CE_n    <= !(w_act || w_state == S_WAIT);
            CLE     <= w_act && w_code == 3'b000;
            ALE     <= w_act && w_code == 3'b001;
            WE_n    <= !(w_state == S_PULSE && w_wr);
            RE_n    <= !(w_state == S_PULSE && !w_wr);
            DOS     <= w_act && w_wr;
            DIS     <= w_last && !w_wr;
            cnt_en  <= w_last;
            ecc_en  <= w_last && w_code[2] && w_code[0];
            busy    <= w_state != S_IDLE;
            Done    <= w_done;
            err     <= w_err;
        end
    end
endmodule

// File: tb/tb_nand_timing_engine.sv
// tb_nand_timing_engine: directed-vector bench for nand_timing_engine with a
// default instance and a T_SETUP=0 instance.
module tb_nand_timing_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [2:0]  cmd_code = 3'b000;
    logic [11:0] burst_len = '0;
    logic        rb_n = 1'b1;
    logic        ce_a, cle_a, ale_a, we_a, re_a, dos_a, dis_a, cnt_a, ecc_a, busy_a, done_a, err_a;
    logic        ce_b, cle_b, ale_b, we_b, re_b, dos_b, dis_b, cnt_b, ecc_b, busy_b, done_b, err_b;
    logic [11:0] exp;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [11:0] RST_VEC = 12'b1001_1000_0000;

    wire [11:0] obs_a = {ce_a, cle_a, ale_a, we_a, re_a, dos_a, dis_a, cnt_a, ecc_a, busy_a, done_a, err_a};
    wire [11:0] obs_b = {ce_b, cle_b, ale_b, we_b, re_b, dos_b, dis_b, cnt_b, ecc_b, busy_b, done_b, err_b};

    always #5 clk = ~clk;

    nand_timing_engine #(.CNT_W(12), .T_SETUP(1), .T_PULSE(2), .T_HOLD(1), .T_WB(4), .T_RB_MAX(1024)) u_dut (
        .CLK(clk), .RES(rst), .start(start_a), .cmd_code(cmd_code), .burst_len(burst_len), .RB_n(rb_n),
        .CE_n(ce_a), .CLE(cle_a), .ALE(ale_a), .WE_n(we_a), .RE_n(re_a), .DOS(dos_a), .DIS(dis_a),
        .cnt_en(cnt_a), .ecc_en(ecc_a), .busy(busy_a), .Done(done_a), .err(err_a)
    );

    nand_timing_engine #(.CNT_W(12), .T_SETUP(0), .T_PULSE(2), .T_HOLD(1), .T_WB(4), .T_RB_MAX(1024)) u_dut0 (
        .CLK(clk), .RES(rst), .start(start_b), .cmd_code(cmd_code), .burst_len(burst_len), .RB_n(rb_n),
        .CE_n(ce_b), .CLE(cle_b), .ALE(ale_b), .WE_n(we_b), .RE_n(re_b), .DOS(dos_b), .DIS(dis_b),
        .cnt_en(cnt_b), .ecc_en(ecc_b), .busy(busy_b), .Done(done_b), .err(err_b)
    );

    // Leaves the bench at the sampling point of cycle 1 (start sampled at edge 0).
    task automatic start_op(input logic sel, input logic [2:0] code, input logic [11:0] len);
        @(negedge clk);
        cmd_code = code;
        burst_len = len;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec += 2;
        if (obs_a !== RST_VEC) begin n_err++; $display("FAIL reset_a got=%b exp=%b", obs_a, RST_VEC); end
        if (obs_b !== RST_VEC) begin n_err++; $display("FAIL reset_b got=%b exp=%b", obs_b, RST_VEC); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (obs_a !== RST_VEC) begin n_err++; $display("FAIL post_reset got=%b exp=%b", obs_a, RST_VEC); end
    endtask

    task automatic test_cmd_latch;
        start_op(1'b0, 3'b000, 12'd0);
        for (int c = 1; c <= 6; c++) begin
            exp = {!(c <= 4), c <= 4, 1'b0, !(c == 2 || c == 3), 1'b1, c <= 4, 1'b0, c == 4, 1'b0, c <= 4, c == 5, 1'b0};
            n_vec++;
            if (obs_a !== exp) begin n_err++; $display("FAIL cmd_latch c=%0d got=%b exp=%b", c, obs_a, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_burst_read;
        int ph;
        int in;
        start_op(1'b0, 3'b100, 12'd4);
        for (int c = 1; c <= 19; c++) begin
            ph = (c - 1) % 4;
            in = (c <= 16) ? 1 : 0;
            exp = {in == 0, 1'b0, 1'b0, 1'b1, !(in == 1 && (ph == 1 || ph == 2)), 1'b0,
                   in == 1 && ph == 3, in == 1 && ph == 3, 1'b0, in == 1, c == 17, 1'b0};
            n_vec++;
            if (obs_a !== exp) begin n_err++; $display("FAIL burst_read c=%0d got=%b exp=%b", c, obs_a, exp); end
            start_a = (c == 8);
            cmd_code = (c == 8) ? 3'b000 : cmd_code;
            @(negedge clk);
        end
    endtask

    task automatic test_burst_write_ecc(input logic [11:0] len, input int nb);
        int ph;
        int in;
        start_op(1'b1, 3'b111, len);
        for (int c = 1; c <= 3 * nb + 2; c++) begin
            ph = (c - 1) % 3;
            in = (c <= 3 * nb) ? 1 : 0;
            exp = {in == 0, 1'b0, 1'b0, !(in == 1 && ph < 2), 1'b1, in == 1, 1'b0,
                   in == 1 && ph == 2, in == 1 && ph == 2, in == 1, c == 3 * nb + 1, 1'b0};
            n_vec++;
            if (obs_b !== exp) begin n_err++; $display("FAIL write_ecc len=%0d c=%0d got=%b exp=%b", len, c, obs_b, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_wait_rb;
        rb_n = 1'b0;
        repeat (3) @(negedge clk);
        start_op(1'b0, 3'b011, 12'd0);
        for (int c = 1; c <= 24; c++) begin
            exp = {!(c <= 22), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c <= 22, c == 23, 1'b0};
            n_vec++;
            if (obs_a !== exp) begin n_err++; $display("FAIL wait_rb c=%0d got=%b exp=%b", c, obs_a, exp); end
            if (c == 20) begin
                #2 rb_n = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout;
        rb_n = 1'b0;
        start_op(1'b0, 3'b011, 12'd0);
        for (int c = 1; c <= 1026; c++) begin
            exp = {!(c <= 1024), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c <= 1024, c == 1025, c == 1025};
            n_vec++;
            if (obs_a !== exp) begin n_err++; $display("FAIL timeout c=%0d got=%b exp=%b", c, obs_a, exp); end
            @(negedge clk);
        end
        rb_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        int k;
        int in;
        start_op(1'b0, 3'b000, 12'd0);
        for (int c = 1; c <= 11; c++) begin
            k = (c > 5) ? c - 5 : c;
            in = (k <= 4) ? 1 : 0;
            exp = {in == 0, in == 1 && c <= 5, in == 1 && c > 5, !(k == 2 || k == 3), 1'b1, in == 1,
                   1'b0, k == 4, 1'b0, in == 1, k == 5, 1'b0};
            n_vec++;
            if (obs_a !== exp) begin n_err++; $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs_a, exp); end
            start_a = (c == 5);
            cmd_code = (c == 5) ? 3'b001 : cmd_code;
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset;
        logic seen_done;
        start_op(1'b0, 3'b100, 12'd4);
        repeat (5) @(negedge clk);
        n_vec++;
        if (re_a !== 1'b0) begin n_err++; $display("FAIL abort_pulse re_n got=%b exp=0", re_a); end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (obs_a !== RST_VEC) begin n_err++; $display("FAIL abort_async got=%b exp=%b", obs_a, RST_VEC); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            seen_done |= done_a | busy_a;
        end
        n_vec++;
        if (seen_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
        start_op(1'b0, 3'b000, 12'd0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (cnt_a !== 1'b1) begin n_err++; $display("FAIL restart_cnt got=%b exp=1", cnt_a); end
        @(negedge clk);
        n_vec++;
        if ({busy_a, done_a} !== 2'b01) begin n_err++; $display("FAIL restart_done got=%b exp=01", {busy_a, done_a}); end
    endtask

    initial begin
        test_reset;
        test_cmd_latch;
        test_burst_read;
        test_burst_write_ecc(12'd3, 3);
        test_burst_write_ecc(12'd0, 1);
        test_wait_rb;
        test_timeout;
        test_back_to_back;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
